rtc_mc_bus_ctrl: RTL and testbench
==================================

Name: rtc_mc_bus_ctrl

Overview:
Transaction sequencer between the external microcontroller bus and the register-file read/write channels of the Microcontroller Interface.
- Accepts one read or write request at a time and checks the address.
- Drives the channel enable, address and data until the register side returns an acknowledge, then returns a one-cycle completion with read data or an error.
- Sits inside rtc_mc_if, in front of the read and write channels.

Parameters:
ADDR_W, 6, address width (register map 0x00-0x3F)
DATA_W, 32, data width
TIMEOUT_CYCLES, 16, cycles to wait for i_ack before error (used only with RTC_BUS_TIMEOUT_EN; min 2, max 255)

Ports:
i_clk  input  1  system clock, rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_cs  input  1  microcontroller chip select / request valid
i_rd  input  1  read request qualifier
i_wr  input  1  write request qualifier
i_addr  input  ADDR_W  request address
i_wdata  input  DATA_W  write data
o_rdata  output  DATA_W  read data, valid when o_ready=1 and o_err=0
o_ready  output  1  one-cycle transaction completion pulse
o_err  output  1  one-cycle error flag, coincident with o_ready
o_busy  output  1  transaction in progress (state != IDLE)
o_err_sticky  output  1  latched error, set by any error completion
i_err_clr  input  1  clears o_err_sticky
o_rd_en  output  1  read channel enable
o_wr_en  output  1  write channel enable
o_addr  output  ADDR_W  registered address to channels
o_wdata  output  DATA_W  registered write data to channels
i_reg_r_data  input  DATA_W  read data from read channel
i_ack  input  1  register-side acknowledge

Behaviour:
- Reset (async, i_reset_n=0):
  - state=IDLE.
  - All outputs 0, including o_rdata, o_addr, o_wdata and o_err_sticky.
  - Enables drop immediately, even mid-transaction; the in-flight transaction is discarded with no o_ready.
- States: IDLE, RD_WAIT, WR_WAIT, DONE, ERR.
- IDLE: sampled every cycle; request = i_cs=1.
  - i_rd=1, i_wr=0, address read-valid: latch o_addr → RD_WAIT.
  - i_wr=1, i_rd=0, address write-valid: latch o_addr and o_wdata → WR_WAIT.
  - i_rd=i_wr=1, i_rd=i_wr=0, or address invalid for the operation: → ERR; no enable is asserted.
- Address sets:
  - Read-valid: 0x00-0x08 and 0x14-0x20.
  - Write-valid: 0x00-0x08 and 0x14-0x1F (0x20 is read-only).
- RD_WAIT: o_rd_en=1. On i_ack=1: capture i_reg_r_data into o_rdata → DONE.
- WR_WAIT: o_wr_en=1. On i_ack=1 → DONE.
- i_ack outside RD_WAIT/WR_WAIT is ignored.
- DONE: o_ready=1, o_err=0 for exactly one cycle → IDLE. o_rdata holds until the next completion; a write completion leaves o_rdata unchanged.
- ERR: o_ready=1, o_err=1 for one cycle; o_rdata forced to 0; o_err_sticky set → IDLE.
- i_cs, i_rd, i_wr, i_addr and i_wdata are ignored in every state except IDLE.
- A master holding i_cs high after o_ready issues a new request on the following IDLE cycle.
- Latency:
  - Request sampled at cycle N; o_rd_en/o_wr_en high from N+1.
  - With i_ack at cycle M (M >= N+1), o_ready pulses at M+1.
  - Minimum request-to-ready latency is 2 cycles.
  - Error from IDLE: o_ready/o_err at N+1.
- o_busy=1 in RD_WAIT, WR_WAIT, DONE and ERR.
- o_err_sticky:
  - Set on ERR entry.
  - i_err_clr clears it; if set and clear occur in the same cycle, set wins.
- o_rd_en and o_wr_en are never high together.

Optional Feature:
RTC_BUS_TIMEOUT_EN
- Defined:
  - An 8-bit wait counter clears on entry to RD_WAIT/WR_WAIT and increments each wait cycle without i_ack.
  - When the count reaches TIMEOUT_CYCLES with no i_ack → ERR (enables drop next cycle, o_ready/o_err pulse).
  - i_ack in the same cycle as the terminal count takes priority (normal DONE).
- Not defined: no counter; the block waits indefinitely for i_ack.

Test Plan:
- Read 0x14, i_ack 3 cycles after o_rd_en, i_reg_r_data=0xDEADBEEF -> o_rd_en high 3 cycles, o_ready=1/o_err=0 one cycle later, o_rdata=0xDEADBEEF.
- Write 0x05 with i_wdata=0x0000_00A5, i_ack immediately -> o_wr_en 1 cycle, o_wdata=0xA5, o_addr=0x05, o_ready 2 cycles after request, o_rdata unchanged.
- Read 0x0A, write 0x20, and i_rd=i_wr=1 at 0x00 -> each gives o_ready=o_err=1 at N+1, no enable asserted, o_err_sticky=1; i_err_clr -> o_err_sticky=0.
- RTC_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, read 0x00 with no ack -> after 16 wait cycles o_ready=o_err=1, o_rdata=0; rerun with i_ack on the 16th cycle -> normal DONE.
- i_reset_n low while in RD_WAIT -> o_rd_en and all outputs 0 asynchronously, no o_ready; after release, a read of 0x01 completes normally.
- i_cs held high across two reads (0x02 then 0x03) -> two separate o_ready pulses, o_busy low exactly one IDLE cycle between them.

Source files
------------

// File: rtl/rtc_mc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_mc_bus_ctrl
//
// Transaction sequencer between the microcontroller bus and the register-file
// read/write channels of the Microcontroller Interface (sits inside rtc_mc_if).
// One request is accepted at a time from IDLE. The address is checked against
// the read- or write-valid map. A valid request drives the channel enable,
// address and data until the register side acknowledges. Every request ends
// in exactly one o_ready pulse, and o_err is high with it on failure.
//
// Optional feature (compile-time macro):
//   RTC_BUS_TIMEOUT_EN - an 8-bit wait counter aborts a channel access that is
//                        not acknowledged within TIMEOUT_CYCLES wait cycles.
//                        Without the macro the block waits for i_ack forever.
//
// Ports:
//   i_clk, i_reset_n        clock (rising edge), async active-low reset
//   i_cs, i_rd, i_wr        request valid and read/write qualifiers
//   i_addr, i_wdata         request address and write data
//   o_rdata                 read data, valid with o_ready=1 and o_err=0
//   o_ready, o_err          one-cycle completion pulse and its error flag
//   o_busy                  transaction in progress (state != IDLE)
//   o_err_sticky, i_err_clr latched error flag and its clear
//   o_rd_en, o_wr_en        read / write channel enables (mutually exclusive)
//   o_addr, o_wdata         registered address / write data to the channels
//   i_reg_r_data            read data from the read channel
//   i_ack                   register-side acknowledge
// ---------------------------------------------------------------------------
module rtc_mc_bus_ctrl #(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cs,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ready,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_err_sticky,
  input  logic              i_err_clr,
  output logic              o_rd_en,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_reg_r_data,
  input  logic              i_ack
);

  // The wait counter is 8 bits wide, so the timeout must fit in 2..255.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rtc_mc_bus_ctrl: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sticky_q, sticky_d;

`ifdef RTC_BUS_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          wait_cnt_q, wait_cnt_d;
`endif

  // Read map: 0x00-0x08 and 0x14-0x20.
  function automatic logic rd_addr_ok(input logic [ADDR_W-1:0] a);
    int unsigned v;
    v = int'(a);
    return (v <= 32'h08) || (v >= 32'h14 && v <= 32'h20);
  endfunction

  // Write map: same as read, except 0x20 is read-only.
  function automatic logic wr_addr_ok(input logic [ADDR_W-1:0] a);
    int unsigned v;
    v = int'(a);
    return (v <= 32'h08) || (v >= 32'h14 && v <= 32'h1F);
  endfunction

  // NOTE: every variable written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef RTC_BUS_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef RTC_BUS_TIMEOUT_EN
        wait_cnt_d = '0;  // cleared here, so every wait state starts at zero
`endif
        if (i_cs) begin
          if (i_rd && !i_wr && rd_addr_ok(i_addr)) begin
            addr_d  = i_addr;
            state_d = RD_WAIT;
          end else if (i_wr && !i_rd && wr_addr_ok(i_addr)) begin
            addr_d  = i_addr;
            wdata_d = i_wdata;
            state_d = WR_WAIT;
          end else begin
            state_d = ERR;  // ambiguous/empty qualifier or bad address
          end
        end
      end

      RD_WAIT: begin
        if (i_ack) begin
          rdata_d = i_reg_r_data;
          state_d = DONE;
        end
`ifdef RTC_BUS_TIMEOUT_EN
        // An acknowledge on the terminal count still wins.
        else if (wait_cnt_q == WaitLast) state_d = ERR;
        else                             wait_cnt_d = wait_cnt_q + 8'd1;
`endif
      end

      WR_WAIT: begin
        if (i_ack) begin
          state_d = DONE;
        end
`ifdef RTC_BUS_TIMEOUT_EN
        else if (wait_cnt_q == WaitLast) state_d = ERR;
        else                             wait_cnt_d = wait_cnt_q + 8'd1;
`endif
      end

      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An error completion presents zero read data.
    if (state_d == ERR) rdata_d = '0;
  end

  // A new error outranks a simultaneous clear.
  assign sticky_d = (state_d == ERR) || (sticky_q && !i_err_clr);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef RTC_BUS_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) wait_cnt_q <= '0;
    else            wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Strobes decode straight from the state register, so the asynchronous
  // reset drops them at once, even mid-transaction.
  assign o_rd_en      = (state_q == RD_WAIT);
  assign o_wr_en      = (state_q == WR_WAIT);
  assign o_ready      = (state_q == DONE) || (state_q == ERR);
  assign o_err        = (state_q == ERR);
  assign o_busy       = (state_q != IDLE);
  assign o_err_sticky = sticky_q;
  assign o_addr       = addr_q;
  assign o_wdata      = wdata_q;
  assign o_rdata      = rdata_q;

endmodule

// File: tb/tb_rtc_mc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rtc_mc_bus_ctrl
//
// Directed bench for rtc_mc_bus_ctrl. Inputs change 1 ns after a rising edge.
// Outputs are sampled at that same point, well away from the next edge.
// Expected values are written by hand in each step.
// ---------------------------------------------------------------------------
module tb_rtc_mc_bus_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              cs, rd, wr, err_clr, ack;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, reg_r_data;
  logic [DATA_W-1:0] rdata_o, wdata_o;
  logic [ADDR_W-1:0] addr_o;
  logic              ready_o, err_o, busy_o, sticky_o, rd_en_o, wr_en_o;

  int errors = 0;
  int checks = 0;

  rtc_mc_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_cs         (cs),
    .i_rd         (rd),
    .i_wr         (wr),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata_o),
    .o_ready      (ready_o),
    .o_err        (err_o),
    .o_busy       (busy_o),
    .o_err_sticky (sticky_o),
    .i_err_clr    (err_clr),
    .o_rd_en      (rd_en_o),
    .o_wr_en      (wr_en_o),
    .o_addr       (addr_o),
    .o_wdata      (wdata_o),
    .i_reg_r_data (reg_r_data),
    .i_ack        (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status outputs as one vector: {rd_en, wr_en, ready, err, busy}.
  function automatic logic [31:0] status();
    return {27'd0, rd_en_o, wr_en_o, ready_o, err_o, busy_o};
  endfunction

  task automatic request(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    cs = 1'b1; rd = r; wr = w; addr = a; wdata = d;
  endtask

  task automatic idle_bus();
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cs = 0; rd = 0; wr = 0; err_clr = 0; ack = 0;
    addr = '0; wdata = '0; reg_r_data = '0;
    #12;
    check("reset_status", status(), 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_addr", {26'd0, addr_o}, 32'h0);
    check("reset_sticky", {31'd0, sticky_o}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Read 0x14, ack on the third rd_en cycle.
    request(1, 0, 6'h14, '0);
    tick();
    idle_bus();
    check("rd14_c1", status(), 32'b10001);
    check("rd14_addr", {26'd0, addr_o}, 32'h14);
    tick();
    check("rd14_c2", status(), 32'b10001);
    tick();
    check("rd14_c3", status(), 32'b10001);
    ack = 1; reg_r_data = 32'hDEADBEEF;
    tick();
    ack = 0; reg_r_data = 32'h1234_5678;
    check("rd14_done", status(), 32'b00101);
    check("rd14_rdata", rdata_o, 32'hDEADBEEF);
    tick();
    check("rd14_idle", status(), 32'b00000);
    check("rd14_hold", rdata_o, 32'hDEADBEEF);

    // Write 0x05 = 0xA5, immediate ack.
    request(0, 1, 6'h05, 32'h0000_00A5);
    tick();
    idle_bus();
    check("wr05_wait", status(), 32'b01001);
    check("wr05_addr", {26'd0, addr_o}, 32'h05);
    check("wr05_wdata", wdata_o, 32'h0000_00A5);
    ack = 1;
    tick();
    ack = 0;
    check("wr05_done", status(), 32'b00101);
    check("wr05_rdata_kept", rdata_o, 32'hDEADBEEF);
    tick();

    // Read of unmapped 0x0A.
    request(1, 0, 6'h0A, '0);
    tick();
    idle_bus();
    check("rd0a_err", status(), 32'b00111);
    check("rd0a_rdata0", rdata_o, 32'h0);
    check("rd0a_sticky", {31'd0, sticky_o}, 32'h1);
    tick();
    check("rd0a_idle", status(), 32'b00000);
    err_clr = 1;
    tick();
    err_clr = 0;
    check("clr_sticky", {31'd0, sticky_o}, 32'h0);

    // Write to read-only 0x20; clear held during the request: set wins.
    request(0, 1, 6'h20, 32'hFFFF_FFFF);
    err_clr = 1;
    tick();
    idle_bus();
    err_clr = 0;
    check("wr20_err", status(), 32'b00111);
    check("wr20_set_wins", {31'd0, sticky_o}, 32'h1);
    tick();
    err_clr = 1;
    tick();
    err_clr = 0;

    // Both qualifiers at 0x00.
    request(1, 1, 6'h00, '0);
    tick();
    idle_bus();
    check("rdwr_err", status(), 32'b00111);
    check("rdwr_sticky", {31'd0, sticky_o}, 32'h1);
    tick();

    // Chip select with neither qualifier.
    request(0, 0, 6'h01, '0);
    tick();
    idle_bus();
    check("none_err", status(), 32'b00111);
    tick();
    err_clr = 1;
    tick();
    err_clr = 0;

    // Boundary: read 0x20 is valid; ack while idle must be ignored.
    ack = 1;
    tick();
    check("ack_idle_ignored", status(), 32'b00000);
    ack = 0;
    request(1, 0, 6'h20, '0);
    tick();
    idle_bus();
    check("rd20_valid", status(), 32'b10001);
    ack = 1; reg_r_data = 32'h0000_0020;
    tick();
    ack = 0;
    check("rd20_done", status(), 32'b00101);
    check("rd20_rdata", rdata_o, 32'h0000_0020);
    tick();

    // Boundary: write 0x09 is just past the low window.
    request(0, 1, 6'h09, 32'h1);
    tick();
    idle_bus();
    check("wr09_err", status(), 32'b00111);
    tick();
    err_clr = 1;
    tick();
    err_clr = 0;

`ifdef RTC_BUS_TIMEOUT_EN
    // No ack: 16 wait cycles, then the error completion.
    request(1, 0, 6'h00, '0);
    tick();
    idle_bus();
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("to_wait%0d", i), status(), 32'b10001);
      tick();
    end
    check("to_err", status(), 32'b00111);
    check("to_rdata0", rdata_o, 32'h0);
    tick();
    // Ack on the 16th wait cycle completes normally.
    request(1, 0, 6'h00, '0);
    tick();
    idle_bus();
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("to_ack_wait%0d", i), status(), 32'b10001);
      if (i == 16) begin ack = 1; reg_r_data = 32'hCAFE_0016; end
      tick();
    end
    ack = 0;
    check("to_ack_done", status(), 32'b00101);
    check("to_ack_rdata", rdata_o, 32'hCAFE_0016);
    tick();
    err_clr = 1;
    tick();
    err_clr = 0;
`else
    // Without the timeout the read waits indefinitely.
    request(1, 0, 6'h00, '0);
    tick();
    idle_bus();
    repeat (20) tick();
    check("no_to_still_wait", status(), 32'b10001);
    ack = 1; reg_r_data = 32'h0000_5A5A;
    tick();
    ack = 0;
    check("no_to_done", status(), 32'b00101);
    check("no_to_rdata", rdata_o, 32'h0000_5A5A);
    tick();
`endif

    // Asynchronous reset while in RD_WAIT.
    request(1, 0, 6'h07, '0);
    tick();
    idle_bus();
    check("rst_pre_rden", status(), 32'b10001);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_status", status(), 32'b00000);
    check("rst_async_rdata", rdata_o, 32'h0);
    check("rst_async_addr", {26'd0, addr_o}, 32'h0);
    tick();
    check("rst_no_ready", status(), 32'b00000);
    #2 rst_n = 1'b1;
    tick();
    request(1, 0, 6'h01, '0);
    tick();
    idle_bus();
    check("rd01_wait", status(), 32'b10001);
    ack = 1; reg_r_data = 32'h0000_0101;
    tick();
    ack = 0;
    check("rd01_done", status(), 32'b00101);
    check("rd01_rdata", rdata_o, 32'h0000_0101);
    tick();

    // i_cs held high across two back-to-back reads.
    request(1, 0, 6'h02, '0);
    tick();
    check("b2b_rd02_wait", status(), 32'b10001);
    ack = 1; reg_r_data = 32'h0000_0002;
    addr = 6'h03;  // ignored outside IDLE
    tick();
    ack = 0;
    check("b2b_rd02_done", status(), 32'b00101);
    check("b2b_rd02_rdata", rdata_o, 32'h0000_0002);
    tick();
    check("b2b_gap_idle", status(), 32'b00000);
    tick();
    idle_bus();
    check("b2b_rd03_wait", status(), 32'b10001);
    check("b2b_rd03_addr", {26'd0, addr_o}, 32'h03);
    ack = 1; reg_r_data = 32'h0000_0003;
    tick();
    ack = 0;
    check("b2b_rd03_done", status(), 32'b00101);
    check("b2b_rd03_rdata", rdata_o, 32'h0000_0003);
    tick();
    check("b2b_end_idle", status(), 32'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
